// File: rtl/fsm_pattern_tx.sv
// Serial pattern transmitter: sends a latched PAT_W-bit pattern MSB-first,
// repeat_cnt times, with GAP idle cycles between repetitions, then pulses done.
module fsm_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             abort,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             pattern_end,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = $clog2(PAT_W);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] rep_q,   rep_d;
  logic [BIT_W-1:0] bit_q,   bit_d;
  logic [GAP_W-1:0] gap_q,   gap_d;

  logic bit_out_q, bit_valid_q, pattern_end_q, busy_q, done_q, start_ready_q;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    rep_d   = rep_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          shreg_d = pattern;
          rep_d   = repeat_cnt;
          bit_d   = '0;
          gap_d   = '0;
          state_d = (repeat_cnt != '0) ? S_SEND : S_DONE;
        end
      end
      S_SEND: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          // Rotate rather than shift so the pattern is intact for the next repetition.
          shreg_d = {shreg_q[PAT_W-2:0], shreg_q[PAT_W-1]};
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (rep_q != '0) rep_d = rep_q - REP_ONE;
            if (rep_q <= REP_ONE) begin
              state_d = S_DONE;
            end else if (GAP > 0) begin
              gap_d   = '0;
              state_d = S_GAP;
            end
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_SEND;
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      shreg_q       <= '0;
      rep_q         <= '0;
      bit_q         <= '0;
      gap_q         <= '0;
      bit_out_q     <= 1'b0;
      bit_valid_q   <= 1'b0;
      pattern_end_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      start_ready_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      rep_q         <= rep_d;
      bit_q         <= bit_d;
      gap_q         <= gap_d;
      bit_out_q     <= (state_d == S_SEND) && shreg_d[PAT_W-1];
      bit_valid_q   <= (state_d == S_SEND);
      pattern_end_q <= (state_d == S_SEND) && (bit_d == BIT_LAST);
      busy_q        <= (state_d != S_IDLE);
      done_q        <= (state_d == S_DONE);
      start_ready_q <= (state_d == S_IDLE);
    end
  end

  assign bit_out     = bit_out_q;
  assign bit_valid   = bit_valid_q;
  assign pattern_end = pattern_end_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign start_ready = start_ready_q;

endmodule

// File: tb/tb_fsm_pattern_tx.sv
// Scoreboard bench for fsm_pattern_tx: stimulus pushes expected bits/done with
// their cycle stamps; a negedge monitor pops and compares on every DUT output.
module tb_fsm_pattern_tx;
  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int GAP   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic             abort;
  logic             bit_out, bit_valid, pattern_end, busy, done;

  fsm_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .pattern(pattern), .repeat_cnt(repeat_cnt), .abort(abort),
    .bit_out(bit_out), .bit_valid(bit_valid), .pattern_end(pattern_end),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_done;
    bit b;
    bit pend;
    int at;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected stream for a run handshaken so its first bit is seen at cycle h.
  function automatic void push_run(input logic [PAT_W-1:0] p, input int r, input int h,
                                   input int nbits, input bit with_done);
    exp_t e;
    int n = 0;
    for (int k = 0; k < r; k++) begin
      for (int j = 0; j < PAT_W; j++) begin
        if (n < nbits) begin
          e.is_done = 1'b0;
          e.b       = p[PAT_W-1-j];
          e.pend    = (j == PAT_W - 1);
          e.at      = h + k * (PAT_W + GAP) + j;
          q.push_back(e);
        end
        n++;
      end
    end
    if (with_done) begin
      e.is_done = 1'b1;
      e.b       = 1'b0;
      e.pend    = 1'b0;
      e.at      = (r == 0) ? h : h + r * PAT_W + (r - 1) * GAP;
      q.push_back(e);
    end
  endfunction

  // Called at a negedge; returns at the handshake posedge with h = first-bit cycle.
  task automatic do_req(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] r, output int h);
    logic rdy;
    bit   got = 1'b0;
    start_valid = 1'b1;
    pattern     = p;
    repeat_cnt  = r;
    h = -1;
    for (int i = 0; i < 60; i++) begin
      rdy = start_ready;
      @(posedge clk);
      if (rdy) begin
        h   = cyc + 1;
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: got no start_ready expected handshake");
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_queue", q.size(), 0);
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int c);
    for (int i = 0; i < 300; i++) begin
      if (cyc >= c) break;
      @(negedge clk);
    end
  endtask

  exp_t m;
  always @(negedge clk) begin
    if (!rst) begin
      if (bit_valid || done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got bit_valid=%0b done=%0b expected none (cyc %0d)",
                   bit_valid, done, cyc);
        end else begin
          m = q.pop_front();
          chk("out_kind_done", done, m.is_done);
          chk("out_kind_valid", bit_valid, !m.is_done);
          chk("out_cycle", cyc, m.at);
          if (!m.is_done) begin
            chk("bit_out", bit_out, m.b);
            chk("pattern_end", pattern_end, m.pend);
          end
        end
      end else begin
        chk("idle_bit_out", bit_out, 0);
        chk("idle_pattern_end", pattern_end, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int h, h2;
    rst = 1'b1; start_valid = 1'b0; abort = 1'b0; pattern = '0; repeat_cnt = '0;
    repeat (2) @(negedge clk);
    chk("rst_start_ready", start_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_bit_out", bit_out, 0);
    chk("rst_pattern_end", pattern_end, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single repetition
    do_req(4'b1100, 8'd1, h);
    push_run(4'b1100, 1, h, 4, 1'b1);
    @(negedge clk);
    start_valid = 1'b0;
    chk("t1_busy_first_bit", busy, 1);
    wait_cyc(h + 5);
    chk("t1_ready_after_done", start_ready, 1);
    chk("t1_busy_after_done", busy, 0);
    wait_drain();

    // Three repetitions with gaps
    do_req(4'b1100, 8'd3, h);
    push_run(4'b1100, 3, h, 12, 1'b1);
    @(negedge clk);
    start_valid = 1'b0;
    wait_cyc(h + 4);
    chk("t2_gap_valid", bit_valid, 0);
    chk("t2_gap_busy", busy, 1);
    wait_drain();

    // Zero count
    do_req(4'b1011, 8'd0, h);
    push_run(4'b1011, 0, h, 0, 1'b1);
    @(negedge clk);
    start_valid = 1'b0;
    chk("t3_busy_done_cycle", busy, 1);
    chk("t3_ready_done_cycle", start_ready, 0);
    @(negedge clk);
    chk("t3_busy_after", busy, 0);
    wait_drain();

    // Abort on 2nd bit of repetition 2, then immediate new request
    do_req(4'b1100, 8'd3, h);
    push_run(4'b1100, 3, h, 6, 1'b0);
    @(negedge clk);
    start_valid = 1'b0;
    wait_cyc(h + 7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_abort_valid", bit_valid, 0);
    chk("t4_abort_busy", busy, 0);
    chk("t4_abort_done", done, 0);
    chk("t4_abort_ready", start_ready, 1);
    do_req(4'b0110, 8'd1, h2);
    chk("t4_rearm_cycle", h2, h + 9);
    push_run(4'b0110, 1, h2, 4, 1'b1);
    @(negedge clk);
    start_valid = 1'b0;
    wait_drain();

    // Asynchronous reset during GAP
    do_req(4'b1010, 8'd3, h);
    push_run(4'b1010, 3, h, 4, 1'b0);
    @(negedge clk);
    start_valid = 1'b0;
    wait_cyc(h + 4);
    chk("t5_pre_rst_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("t5_async_busy", busy, 0);
    chk("t5_async_valid", bit_valid, 0);
    chk("t5_async_done", done, 0);
    chk("t5_async_ready", start_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_post_rst_ready", start_ready, 1);
    do_req(4'b1010, 8'd1, h);
    push_run(4'b1010, 1, h, 4, 1'b1);
    @(negedge clk);
    start_valid = 1'b0;
    wait_drain();

    // start_valid held, inputs changed while busy
    do_req(4'b1100, 8'd2, h);
    push_run(4'b1100, 2, h, 8, 1'b1);
    @(negedge clk);
    pattern    = 4'b0110;
    repeat_cnt = 8'd1;
    push_run(4'b0110, 1, h + 12, 4, 1'b1);
    wait_cyc(h + 11);
    chk("t6_idle_ready", start_ready, 1);
    wait_cyc(h + 12);
    start_valid = 1'b0;
    chk("t6_second_busy", busy, 1);
    wait_drain();
    repeat (3) @(negedge clk);
    chk("final_queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_pattern_tx.md
Name: fsm_pattern_tx

Overview:
Serial pattern generator: the transmit-side counterpart of the team's serial bit-pattern detectors. It accepts a PAT_W-bit pattern and a repeat count over a valid/ready handshake. It then emits the pattern MSB-first, one bit per clock, the requested number of times, with GAP idle cycles between repetitions. It drives test and link stimulus into downstream sequence detectors and signals completion with a one-cycle done pulse.

Parameters:
PAT_W, 4, pattern width in bits; PAT_W >= 2.
CNT_W, 8, width of the repeat count.
GAP, 2, idle cycles inserted between repetitions; 0 means back-to-back.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  reset, asynchronous, active-high.
start_valid  input  1  request to start a transmission.
start_ready  output  1  high when a request can be accepted.
pattern  input  PAT_W  pattern to send; bit PAT_W-1 is sent first.
repeat_cnt  input  CNT_W  number of repetitions; 0 is legal.
abort  input  1  synchronous cancel of an ongoing transmission.
bit_out  output  1  serial data.
bit_valid  output  1  bit_out carries a pattern bit this cycle.
pattern_end  output  1  the current valid bit is the last bit of a repetition.
busy  output  1  block is not in IDLE.
done  output  1  one-cycle pulse on normal completion.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. While rst is high: state=IDLE, shift register=0, repetition counter=0, bit counter=0, gap counter=0, bit_out=0, bit_valid=0, pattern_end=0, done=0, busy=0, start_ready=1.
- Output timing: all outputs are decoded from registered state only. There is no combinational path from any input to any output.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - start_ready=1.
  - Handshake occurs when start_valid && start_ready at a rising edge: latch pattern into the shift register and repeat_cnt into the repetition counter, clear the bit counter.
  - If repeat_cnt!=0, go to SEND; if repeat_cnt==0, go to DONE.
- SEND:
  - bit_valid=1 and bit_out=shreg[PAT_W-1]. Shift left by one each cycle, using a rotate so the pattern is restored for the next repetition.
  - The first bit is valid on the cycle immediately after the handshake (latency 1).
  - pattern_end=1 when bit counter==PAT_W-1. On that cycle the repetition counter decrements.
  - At pattern_end: if repetitions remain, go to GAP (GAP>0) or stay in SEND with the bit counter cleared (GAP=0). If no repetitions remain, go to DONE.
- GAP: bit_valid=0, bit_out=0. Stay exactly GAP cycles, then go to SEND.
- DONE: done=1 for exactly one cycle, start_ready=0, then go to IDLE.
- busy = (state != IDLE). start_ready = (state == IDLE).
- Total activity: repeat_cnt*PAT_W + (repeat_cnt-1)*GAP cycles of SEND/GAP, then the done pulse on the next cycle.
- abort: sampled in SEND or GAP. On the next cycle: state=IDLE, bit_valid=0, pattern_end=0, no done pulse. abort is ignored in IDLE and DONE. abort has priority over pattern_end and counter updates in the same cycle.
- start_valid while not in IDLE is ignored. Inputs are not re-sampled, and pattern and repeat_cnt may change freely once latched.
- Back-to-back requests: a request held high through DONE is accepted on the first IDLE cycle. The minimum gap is 1 IDLE cycle between done and the next first bit's handshake.
- Counter widths: the repetition counter is CNT_W bits with no wrap-around, since it decrements only while nonzero. The bit counter is clog2(PAT_W) bits. The gap counter is sized for GAP (minimum 1 bit).
- Asynchronous rst mid-transmission: outputs drop to their reset values immediately, without waiting for a clock edge. The transmission is discarded and no done pulse is issued.

Test Plan:
1. Single repetition: pattern=4'b1100, repeat_cnt=1, handshake at cycle 0 -> bit_out 1,1,0,0 with bit_valid=1 on cycles 1-4; pattern_end only on cycle 4; done on cycle 5; start_ready=1 on cycle 6.
2. Repetitions with gap: pattern=4'b1100, repeat_cnt=3, GAP=2 -> valid bits on cycles 1-4, 7-10 and 13-16; bit_valid=0 on cycles 5-6 and 11-12; three pattern_end pulses (cycles 4, 10, 16); done on cycle 17.
3. Zero count: repeat_cnt=0 -> bit_valid never asserts; done on cycle 1 after the handshake; busy high for exactly 1 cycle.
4. Abort: repeat_cnt=3, abort on the 2nd bit of repetition 2 (cycle 8) -> bit_valid=0 and busy=0 from cycle 9; no done pulse; a new request is accepted on cycle 9.
5. Asynchronous reset: assert rst between clock edges during GAP -> bit_valid, busy and done go to 0 before the next edge; after release, start_ready=1 and pattern 1010 sends correctly.
6. Handshake rules: with start_valid held high and pattern changed while busy -> the changed pattern is ignored mid-run; the next request is accepted on the IDLE cycle after done and sends the new pattern.
